// File: rtl/ring_pkg.sv
// Shared ring-router definitions: packet layout, route codes and slot-buffer sizing.
package ring_pkg;

    localparam int PACKET_SIZE   = 49;
    localparam int BUFFER_SIZE   = 4;
    localparam int STARVE_LIMIT  = 255;
    localparam int PKT_VALID_BIT = PACKET_SIZE - 1;
    localparam int AGE_MSB       = 47;
    localparam int AGE_LSB       = 32;

    localparam logic [1:0] ROUTE_LOCAL = 2'd0;
    localparam logic [1:0] ROUTE_CW    = 2'd1;
    localparam logic [1:0] ROUTE_CCW   = 2'd2;
    localparam logic [1:0] ROUTE_EJECT = 2'd3;

    typedef logic [PACKET_SIZE-1:0] packet_t;
    typedef logic [1:0]             route_t;

    // A stored packet always carries its valid bit, which doubles as slot occupancy.
    function automatic packet_t mark_valid(input packet_t p);
        packet_t r;
        r = p;
        r[PKT_VALID_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/slot_buffer_ctrl_if.sv
// Link/allocator-facing bundle of the per-input slot manager.
interface slot_buffer_ctrl_if;
    import ring_pkg::*;

    packet_t                       in_packet;
    route_t                        in_route;
    logic                          in_valid;
    logic                          in_high;
    logic                          in_ready_high;
    logic                          in_ready_low;
    logic [15:0]                   grant_pos;
    logic                          grant_valid;
    logic                          grant_in_high;
    packet_t [BUFFER_SIZE-1:0]     buffer_high_prior;
    packet_t [BUFFER_SIZE-1:0]     buffer_low_prior;
    route_t  [BUFFER_SIZE-1:0]     buffer_high_prior_route_info;
    route_t  [BUFFER_SIZE-1:0]     buffer_low_prior_route_info;
    logic [2:0]                    occ_high;
    logic [2:0]                    occ_low;
    logic                          starve;
    logic                          err_grant;

    modport master (
        output in_packet, in_route, in_valid, in_high, grant_pos, grant_valid, grant_in_high,
        input  in_ready_high, in_ready_low, buffer_high_prior, buffer_low_prior,
               buffer_high_prior_route_info, buffer_low_prior_route_info,
               occ_high, occ_low, starve, err_grant
    );

    modport slave (
        input  in_packet, in_route, in_valid, in_high, grant_pos, grant_valid, grant_in_high,
        output in_ready_high, in_ready_low, buffer_high_prior, buffer_low_prior,
               buffer_high_prior_route_info, buffer_low_prior_route_info,
               occ_high, occ_low, starve, err_grant
    );

endinterface

// File: rtl/slot_bank.sv
// One priority class worth of packet slots: insert into lowest free slot, free on grant,
// optional per-slot wait counters for starvation detection.
module slot_bank
    import ring_pkg::*;
#(
    parameter bit EN_WAIT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ins_valid,
    input  packet_t                   ins_packet,
    input  route_t                    ins_route,
    input  logic                      grant_valid,
    input  logic [1:0]                grant_idx,
    output packet_t [BUFFER_SIZE-1:0] slots,
    output route_t  [BUFFER_SIZE-1:0] routes,
    output logic [2:0]                occ,
    output logic                      ready,
    output logic                      grant_err,
    output logic                      starve
);

    packet_t [BUFFER_SIZE-1:0] slots_r;
    route_t  [BUFFER_SIZE-1:0] routes_r;
    logic [2:0]                occ_r;
    logic                      ready_r;
    logic [BUFFER_SIZE-1:0]    valid_s;
    logic [1:0]                free_idx_s;
    logic                      has_free_s;
    logic                      accept_s;
    logic                      hit_s;
    logic [2:0]                occ_next_s;

    // Occupancy view of the slot array.
    always_comb begin
        valid_s = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            valid_s[i] = slots_r[i][PKT_VALID_BIT];
        end
    end

    // Free-slot priority encoder: lowest empty index wins, evaluated on pre-grant state.
    always_comb begin
        free_idx_s = 2'd0;
        has_free_s = 1'b1;
        casez (valid_s)
            4'b???0: free_idx_s = 2'd0;
            4'b??01: free_idx_s = 2'd1;
            4'b?011: free_idx_s = 2'd2;
            4'b0111: free_idx_s = 2'd3;
            default: begin
                free_idx_s = 2'd0;
                has_free_s = 1'b0;
            end
        endcase
    end

    assign accept_s   = ins_valid & ready_r & has_free_s;
    assign hit_s      = grant_valid & valid_s[grant_idx];
    assign grant_err  = grant_valid & ~valid_s[grant_idx];
    assign occ_next_s = occ_r + {2'b00, accept_s} - {2'b00, hit_s};

    // Slot array, occupancy count and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_r  <= '0;
            routes_r <= '0;
            occ_r    <= 3'd0;
            ready_r  <= 1'b1;
        end else begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                if (accept_s && (free_idx_s == 2'(i))) begin
                    slots_r[i]  <= mark_valid(ins_packet);
                    routes_r[i] <= ins_route;
                end else if (hit_s && (grant_idx == 2'(i))) begin
                    slots_r[i]  <= '0;
                    routes_r[i] <= 2'd0;
                end else begin
                    slots_r[i]  <= slots_r[i];
                    routes_r[i] <= routes_r[i];
                end
            end
            occ_r   <= occ_next_s;
            ready_r <= (occ_next_s != 3'(BUFFER_SIZE));
        end
    end

    assign slots  = slots_r;
    assign routes = routes_r;
    assign occ    = occ_r;
    assign ready  = ready_r;

    if (EN_WAIT) begin : g_wait
        logic [7:0] wait_r [BUFFER_SIZE];
        logic       starve_s;

        // Saturating wait counters, cleared whenever the slot is written or granted.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < BUFFER_SIZE; i++) begin
                    wait_r[i] <= 8'd0;
                end
            end else begin
                for (int i = 0; i < BUFFER_SIZE; i++) begin
                    if ((accept_s && (free_idx_s == 2'(i))) ||
                        (grant_valid && (grant_idx == 2'(i)))) begin
                        wait_r[i] <= 8'd0;
                    end else if (valid_s[i] && (wait_r[i] != 8'hFF)) begin
                        wait_r[i] <= wait_r[i] + 8'd1;
                    end else begin
                        wait_r[i] <= wait_r[i];
                    end
                end
            end
        end

        // Any slot at or past the limit raises starvation.
        always_comb begin
            starve_s = 1'b0;
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                starve_s = starve_s | (wait_r[i] >= 8'(STARVE_LIMIT));
            end
        end

        assign starve = starve_s;
    end else begin : g_nowait
        assign starve = 1'b0;
    end

endmodule

// File: rtl/slot_buffer_ctrl.sv
// Per-input slot manager: steers arrivals and grants to the high/low slot banks and
// aggregates the sticky grant error and low-class starvation flag.
module slot_buffer_ctrl
    import ring_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    slot_buffer_ctrl_if.slave  bus
);

    logic ins_high_s;
    logic ins_low_s;
    logic gnt_high_s;
    logic gnt_low_s;
    logic err_high_s;
    logic err_low_s;
    logic starve_high_s;
    logic starve_low_s;
    logic err_grant_r;
    logic unused_grant_hi_s;

    assign ins_high_s = bus.in_valid & bus.in_high;
    assign ins_low_s  = bus.in_valid & ~bus.in_high;
    assign gnt_high_s = bus.grant_valid & bus.grant_in_high;
    assign gnt_low_s  = bus.grant_valid & ~bus.grant_in_high;

    // Only the low two grant bits address a slot in a 4-wide bank.
    assign unused_grant_hi_s = ^bus.grant_pos[15:2];

    slot_bank #(.EN_WAIT(1'b0)) u_high (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (ins_high_s),
        .ins_packet  (bus.in_packet),
        .ins_route   (bus.in_route),
        .grant_valid (gnt_high_s),
        .grant_idx   (bus.grant_pos[1:0]),
        .slots       (bus.buffer_high_prior),
        .routes      (bus.buffer_high_prior_route_info),
        .occ         (bus.occ_high),
        .ready       (bus.in_ready_high),
        .grant_err   (err_high_s),
        .starve      (starve_high_s)
    );

    slot_bank #(.EN_WAIT(1'b1)) u_low (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (ins_low_s),
        .ins_packet  (bus.in_packet),
        .ins_route   (bus.in_route),
        .grant_valid (gnt_low_s),
        .grant_idx   (bus.grant_pos[1:0]),
        .slots       (bus.buffer_low_prior),
        .routes      (bus.buffer_low_prior_route_info),
        .occ         (bus.occ_low),
        .ready       (bus.in_ready_low),
        .grant_err   (err_low_s),
        .starve      (starve_low_s)
    );

    // Sticky error: a grant hit an empty slot in either class; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_grant_r <= 1'b0;
        end else if (err_high_s || err_low_s) begin
            err_grant_r <= 1'b1;
        end else begin
            err_grant_r <= err_grant_r;
        end
    end

    assign bus.err_grant = err_grant_r;
    assign bus.starve    = starve_high_s | starve_low_s;

endmodule

// File: tb/tb_slot_buffer_ctrl.sv
// Scoreboard bench for slot_buffer_ctrl: directed stimulus queues expected state,
// a monitor compares it one cycle later.
module tb_slot_buffer_ctrl;
    import ring_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    slot_buffer_ctrl_if bus();

    slot_buffer_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string      tag;
        int         cyc;
        bit         is_pkt;
        logic [17:0] st;
        bit         hi;
        int         idx;
        packet_t    pkt;
        route_t     rt;
    } exp_t;

    exp_t q[$];

    function automatic packet_t mkp(input logic [15:0] age, input logic [31:0] pay, input bit v);
        packet_t p;
        p = '0;
        p[PKT_VALID_BIT]   = v;
        p[AGE_MSB:AGE_LSB] = age;
        p[31:0]            = pay;
        return p;
    endfunction

    task automatic exp_st(input string tag, input logic [3:0] hv, input logic [3:0] lv,
                          input logic [2:0] oh, input logic [2:0] ol, input logic rh,
                          input logic rl, input logic er, input logic sv);
        exp_t e;
        e.tag = tag; e.cyc = cyc_cnt + 1; e.is_pkt = 1'b0;
        e.st = {hv, lv, oh, ol, rh, rl, er, sv};
        e.hi = 1'b0; e.idx = 0; e.pkt = '0; e.rt = 2'd0;
        q.push_back(e);
    endtask

    task automatic exp_pk(input string tag, input bit hi, input int idx,
                          input packet_t p, input route_t r);
        exp_t e;
        e.tag = tag; e.cyc = cyc_cnt + 1; e.is_pkt = 1'b1;
        e.st = '0; e.hi = hi; e.idx = idx; e.pkt = p; e.rt = r;
        q.push_back(e);
    endtask

    task automatic drive(input bit iv, input bit ih, input packet_t p, input route_t r,
                         input bit gv, input bit gh, input logic [15:0] gp);
        bus.in_valid      = iv;
        bus.in_high       = ih;
        bus.in_packet     = p;
        bus.in_route      = r;
        bus.grant_valid   = gv;
        bus.grant_in_high = gh;
        bus.grant_pos     = gp;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] snap();
        logic [3:0] hv;
        logic [3:0] lv;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            hv[i] = bus.buffer_high_prior[i][PKT_VALID_BIT];
            lv[i] = bus.buffer_low_prior[i][PKT_VALID_BIT];
        end
        return {hv, lv, bus.occ_high, bus.occ_low, bus.in_ready_high, bus.in_ready_low,
                bus.err_grant, bus.starve};
    endfunction

    exp_t    m_e;
    packet_t m_p;
    route_t  m_r;

    // Monitor: pops every expectation due this cycle and compares it with the DUT.
    always @(posedge clk) begin
        #2;
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            m_e = q.pop_front();
            n_cmp++;
            if (m_e.cyc != cyc_cnt) begin
                n_mis++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", m_e.tag, cyc_cnt, m_e.cyc);
            end else if (m_e.is_pkt) begin
                m_p = m_e.hi ? bus.buffer_high_prior[m_e.idx] : bus.buffer_low_prior[m_e.idx];
                m_r = m_e.hi ? bus.buffer_high_prior_route_info[m_e.idx]
                             : bus.buffer_low_prior_route_info[m_e.idx];
                if ({m_p, m_r} !== {m_e.pkt, m_e.rt}) begin
                    n_mis++;
                    $display("FAIL %s: got pkt=%h route=%0d, required pkt=%h route=%0d",
                             m_e.tag, m_p, m_r, m_e.pkt, m_e.rt);
                end
            end else if (snap() !== m_e.st) begin
                n_mis++;
                $display("FAIL %s: got {hv,lv,oh,ol,rh,rl,err,starve}=%b, required %b",
                         m_e.tag, snap(), m_e.st);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        exp_st("reset", 4'h0, 4'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Fill the low bank; the first packet arrives with its valid bit clear.
        drive(1'b1, 1'b0, mkp(16'd10, 32'hA0, 1'b0), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_lo0", 4'h0, 4'h1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("lo0_pkt", 1'b0, 0, mkp(16'd10, 32'hA0, 1'b1), ROUTE_CW);
        tick();
        drive(1'b1, 1'b0, mkp(16'd20, 32'hA1, 1'b1), ROUTE_CCW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_lo1", 4'h0, 4'h3, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("lo1_pkt", 1'b0, 1, mkp(16'd20, 32'hA1, 1'b1), ROUTE_CCW);
        tick();
        drive(1'b1, 1'b0, mkp(16'd30, 32'hA2, 1'b1), ROUTE_EJECT, 1'b0, 1'b0, 16'd0);
        exp_st("ins_lo2", 4'h0, 4'h7, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, mkp(16'd40, 32'hA3, 1'b1), ROUTE_LOCAL, 1'b0, 1'b0, 16'd0);
        exp_st("ins_lo3_full", 4'h0, 4'hF, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pk("lo3_pkt", 1'b0, 3, mkp(16'd40, 32'hA3, 1'b1), ROUTE_LOCAL);
        tick();

        drive(1'b1, 1'b0, mkp(16'd99, 32'hBAD, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("drop_full", 4'h0, 4'hF, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pk("drop_keep_lo2", 1'b0, 2, mkp(16'd30, 32'hA2, 1'b1), ROUTE_EJECT);
        tick();

        // Upper grant_pos bits must be ignored.
        drive(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b0, 16'hFFF6);
        exp_st("grant_lo2", 4'h0, 4'hB, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("lo2_cleared", 1'b0, 2, '0, 2'd0);
        tick();
        drive(1'b1, 1'b0, mkp(16'd50, 32'hA4, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("refill_lo2", 4'h0, 4'hF, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pk("lo2_refill_pkt", 1'b0, 2, mkp(16'd50, 32'hA4, 1'b1), ROUTE_CW);
        tick();

        // Full bank: same-cycle grant does not make room for the insert.
        drive(1'b1, 1'b0, mkp(16'd60, 32'hA5, 1'b1), ROUTE_CW, 1'b1, 1'b0, 16'd0);
        exp_st("full_grant_ins", 4'h0, 4'hE, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("lo0_cleared", 1'b0, 0, '0, 2'd0);
        tick();

        drive(1'b1, 1'b1, mkp(16'd1, 32'hB0, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_hi0", 4'h1, 4'hE, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, mkp(16'd2, 32'hB1, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_hi1", 4'h3, 4'hE, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, mkp(16'd3, 32'hB2, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_hi2", 4'h7, 4'hE, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        drive(1'b1, 1'b1, mkp(16'd4, 32'hB3, 1'b1), ROUTE_CCW, 1'b1, 1'b1, 16'd0);
        exp_st("hi_ins_grant", 4'hE, 4'hE, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("hi3_pkt", 1'b1, 3, mkp(16'd4, 32'hB3, 1'b1), ROUTE_CCW);
        exp_pk("hi0_cleared", 1'b1, 0, '0, 2'd0);
        tick();

        drive(1'b1, 1'b0, mkp(16'd70, 32'hA6, 1'b1), ROUTE_LOCAL, 1'b1, 1'b1, 16'd3);
        exp_st("cross_class", 4'h6, 4'hF, 3'd2, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pk("lo0_pkt2", 1'b0, 0, mkp(16'd70, 32'hA6, 1'b1), ROUTE_LOCAL);
        tick();

        drive(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b1, 16'd1);
        exp_st("grant_hi1", 4'h4, 4'hF, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b1, 16'd1);
        exp_st("grant_empty_err", 4'h4, 4'hF, 3'd1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, mkp(16'd5, 32'hB4, 1'b1), ROUTE_EJECT, 1'b0, 1'b0, 16'd0);
        exp_st("err_sticky", 4'h5, 4'hF, 3'd2, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_pk("hi0_pkt", 1'b1, 0, mkp(16'd5, 32'hB4, 1'b1), ROUTE_EJECT);
        tick();
        drive(1'b1, 1'b1, mkp(16'd6, 32'hB5, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("ins_hi_s1", 4'h7, 4'hF, 3'd3, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, mkp(16'd8, 32'hB6, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("both_full", 4'hF, 4'hF, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset mid-operation wins over a concurrent insert.
        rst = 1'b1;
        drive(1'b1, 1'b0, mkp(16'd9, 32'hC0, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("mid_reset", 4'h0, 4'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_pk("lo1_after_rst", 1'b0, 1, '0, 2'd0);
        tick();
        rst = 1'b0;

        // Starvation: a single low slot left unserved.
        drive(1'b1, 1'b0, mkp(16'd7, 32'hD0, 1'b1), ROUTE_CW, 1'b0, 1'b0, 16'd0);
        exp_st("starve_ins", 4'h0, 4'h1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 253; i++) tick();
        exp_st("wait_254", 4'h0, 4'h1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        exp_st("wait_255", 4'h0, 4'h1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        exp_st("wait_sat", 4'h0, 4'h1, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b0, 16'd0);
        exp_st("starve_clear", 4'h0, 4'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        #5;

        if (q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL leftover: got %0d unchecked expectations, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
